// File: rtl/sample_capture_ctrl.sv
// sample_capture_ctrl
// Packs 8-bit samples into 64-bit words for one triggered frame, counts words
// against a latched frame length, and hands words downstream through a
// single-entry valid/ready output slot. Words that form while the slot is
// still held by the consumer are dropped and accounted in overflow/drop_cnt.

module sample_capture_ctrl #(
  parameter int BYTES_PER_WORD = 8,
  parameter int LEN_W          = 16
) (
  input  logic                        clk_50mhz,
  input  logic                        rst,
  input  logic                        arm,
  input  logic                        abort,
  input  logic                        trigger,
  input  logic [LEN_W-1:0]            frame_len,
  input  logic [7:0]                  sample_in,
  input  logic                        sample_vld,
  output logic [8*BYTES_PER_WORD-1:0] out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_last,
  output logic                        busy,
  output logic                        done,
  output logic                        overflow,
  output logic [7:0]                  drop_cnt
);

  localparam int WORD_W = 8 * BYTES_PER_WORD;
  localparam int IDX_W  = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam logic [IDX_W-1:0] LAST_LANE = IDX_W'(BYTES_PER_WORD - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_CAPTURE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t              state;
  logic [LEN_W-1:0]    frame_len_q;   // words in the current frame
  logic [LEN_W-1:0]    word_cnt;      // words formed so far, dropped or not
  logic [IDX_W-1:0]    byte_idx;      // next lane to fill
  logic [WORD_W-1:0]   pack_q;        // lanes 0..N-2 of the word being built

  logic                take;          // consumer takes the slot on this edge
  logic                slot_free;     // a newly formed word may load this edge
  logic                lane_wr;       // a sample is accepted into a lane
  logic                word_formed;   // the accepted sample completes a word
  logic                final_word;    // the completed word is the last of the frame
  logic                word_loaded;   // the completed word enters the slot
  logic [WORD_W-1:0]   formed_word;   // completed word including the current sample

  // Handshake and word-completion decode shared by datapath and control.
  // NOTE: every signal gets a value at the top of the block so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    take        = out_valid && out_ready;
    slot_free   = !out_valid || out_ready;
    lane_wr     = (state == S_CAPTURE) && sample_vld;
    word_formed = lane_wr && (byte_idx == LAST_LANE);
    final_word  = word_formed && (word_cnt == frame_len_q - LEN_W'(1));
    word_loaded = word_formed && slot_free;
    formed_word = pack_q;
    formed_word[WORD_W-1 -: 8] = sample_in;
  end

  // Lane packing and the output data register.
  // NOTE: the packing buffer is an ordinary register bank and is cleared on
  // reset and abort so a restarted frame never exposes stale lanes.
  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      pack_q   <= '0;
      out_data <= '0;
    end else if (abort) begin
      pack_q <= '0;
    end else begin
      if (lane_wr) begin
        pack_q[int'(byte_idx) * 8 +: 8] <= sample_in;
      end
      if (word_loaded) begin
        out_data <= formed_word;
      end
    end
  end

  // Frame sequencing, output slot flags, status and drop accounting.
  // NOTE: all state here updates with non-blocking assignments so every
  // register samples the pre-edge values, regardless of statement order.
  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      state       <= S_IDLE;
      frame_len_q <= '0;
      word_cnt    <= '0;
      byte_idx    <= '0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      overflow    <= 1'b0;
      drop_cnt    <= '0;
    end else if (abort) begin
      // Abort discards the frame but keeps the drop statistics for inspection.
      state     <= S_IDLE;
      word_cnt  <= '0;
      byte_idx  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;

      // Slot empties when taken; a word loading on the same edge overrides below.
      if (take) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (arm && (frame_len != '0)) begin
            frame_len_q <= frame_len;
            word_cnt    <= '0;
            byte_idx    <= '0;
            overflow    <= 1'b0;
            drop_cnt    <= '0;
            busy        <= 1'b1;
            state       <= S_ARMED;
          end
        end

        S_ARMED: begin
          if (trigger) begin
            state <= S_CAPTURE;
          end
        end

        S_CAPTURE: begin
          if (lane_wr) begin
            byte_idx <= word_formed ? '0 : byte_idx + IDX_W'(1);
          end
          if (word_formed) begin
            word_cnt <= word_cnt + LEN_W'(1);
            if (slot_free) begin
              out_valid <= 1'b1;
              out_last  <= final_word;
            end else begin
              overflow <= 1'b1;
              if (drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 8'd1;
              end
            end
            if (final_word) begin
              state <= S_DRAIN;
            end
          end
        end

        S_DRAIN: begin
          // Finish once the last presented word has left the slot.
          if (!out_valid || take) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
